pb_press_driver: RTL and testbench

//  Transmit side of the push-button line: turns one-cycle press requests into

---
 rtl/pb_press_driver.sv | 110 +++++++++++
 tb/tb_pb_press_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pb_press_driver.sv
// Turns one-cycle press requests into active-low button pulses: LOW_CYCLES low, then at least GAP_CYCLES high.
// Requests arriving mid-press queue in a saturating pending counter; overflow drops with a one-cycle pulse.
module pb_press_driver #(
    parameter int LOW_CYCLES  = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int QUEUE_DEPTH = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               press,
    output logic                               PB_out,
    output logic                               release_sent,
    output logic                               busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending,
    output logic                               dropped
);
    localparam int PW   = $clog2(QUEUE_DEPTH + 1);
    localparam int MAXC = (LOW_CYCLES > GAP_CYCLES) ? LOW_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [PW-1:0] pending_nxt;
    logic          pb_nxt, rs_nxt, drop_nxt;
    logic          start, take, from_q, full;

    always_comb begin
        start  = (pending != '0) | press;
        take   = start && ((state == IDLE) || ((state == GAP) && (cnt == '0)));
        from_q = take && (pending != '0);
        full   = (pending == PW'(QUEUE_DEPTH));

        // A press that coincides with a take from an empty queue leaves directly and is never counted.
        pending_nxt = pending;
        drop_nxt    = 1'b0;
        if (from_q) begin
            if (!press)
                pending_nxt = pending - PW'(1);
        end else if (press && !take) begin
            if (full)
                drop_nxt = 1'b1;
            else
                pending_nxt = pending + PW'(1);
        end

        state_nxt = state;
        cnt_nxt   = cnt;
        pb_nxt    = PB_out;
        rs_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = LOW;
                    pb_nxt    = 1'b0;
                    cnt_nxt   = CW'(LOW_CYCLES - 1);
                end
            end
            LOW: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = GAP;
                    pb_nxt    = 1'b1;
                    rs_nxt    = 1'b1;
                    cnt_nxt   = CW'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else if (take) begin
                    state_nxt = LOW;
                    pb_nxt    = 1'b0;
                    cnt_nxt   = CW'(LOW_CYCLES - 1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                pb_nxt    = 1'b1;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            PB_out       <= 1'b1;
            release_sent <= 1'b0;
            busy         <= 1'b0;
            pending      <= '0;
            dropped      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            PB_out       <= pb_nxt;
            release_sent <= rs_nxt;
            busy         <= (state_nxt != IDLE) || (pending_nxt != '0);
            pending      <= pending_nxt;
            dropped      <= drop_nxt;
        end
    end
endmodule

// File: tb/tb_pb_press_driver.sv
// Bench for pb_press_driver: directed scenarios plus random bursts against a timestamp-based reference.
module tb_pb_press_driver;
    localparam int L  = 4;
    localparam int G  = 4;
    localparam int QD = 3;
    localparam int PW = $clog2(QD + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          press = 1'b0;
    logic          PB_out, release_sent, busy, dropped;
    logic [PW-1:0] pending;

    pb_press_driver #(.LOW_CYCLES(L), .GAP_CYCLES(G), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .press(press), .PB_out(PB_out),
        .release_sent(release_sent), .busy(busy), .pending(pending), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: line is a timeline; a press may start once the previous one's low+gap window has elapsed.
    int t = 0;
    int m_pending, last_start, free_at, m_takes;
    bit m_drop;
    int rel_cnt, drop_cnt, press_cnt;
    bit prev_pb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        m_pending  = 0;
        last_start = -1000;
        free_at    = -1000;
        m_drop     = 1'b0;
        prev_pb    = 1'b1;
    endtask

    task automatic clear_counts();
        rel_cnt = 0; drop_cnt = 0; press_cnt = 0; m_takes = 0;
    endtask

    task automatic model_edge(input bit p);
        t++;
        m_drop = 1'b0;
        if (t >= free_at && (m_pending > 0 || p)) begin
            last_start = t;
            free_at    = t + L + G;
            m_takes++;
            if (m_pending > 0 && !p) m_pending--;
        end else if (p) begin
            if (m_pending < QD) m_pending++;
            else m_drop = 1'b1;
        end
    endtask

    task automatic chk_all();
        bit in_low;
        in_low = (t >= last_start) && (t < last_start + L);
        chk("pb_out", PB_out, !in_low);
        chk("release_sent", release_sent, t == last_start + L);
        chk("pending", pending, m_pending);
        chk("dropped", dropped, m_drop);
        chk("busy", busy, (m_pending > 0) || (t < free_at));
        if (!prev_pb && PB_out) rel_cnt++;
        if (dropped) drop_cnt++;
        prev_pb = PB_out;
    endtask

    task automatic step(input bit p);
        press = p;
        if (p) press_cnt++;
        @(posedge clk);
        model_edge(p);
        @(negedge clk);
        chk_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        bit pb_exp [10];
        bit p;
        model_reset();
        clear_counts();
        repeat (3) @(negedge clk);
        chk("rst_pb", PB_out, 1);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_release", release_sent, 0);
        chk("rst_dropped", dropped, 0);
        rst_n = 1'b1;

        // Single press: low for edges 0..3, release at 4, idle again at 8.
        pb_exp = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 10; i++) begin
            step(i == 0);
            chk("t1_pb", PB_out, pb_exp[i]);
            chk("t1_rs", release_sent, i == 4);
            chk("t1_busy", busy, i < 8);
            chk("t1_pend", pending, 0);
        end

        // Three back-to-back requests queue and drain at 8-edge intervals.
        clear_counts();
        for (int i = 0; i < 26; i++) begin
            step(i < 3);
            if (i <= 2) chk("t2_pend_fill", pending, i);
            if (i == 8) chk("t2_pend_e8", pending, 1);
            if (i == 16) chk("t2_pend_e16", pending, 0);
            if (i == 8 || i == 16) chk("t2_pb_restart", PB_out, 0);
        end
        chk("t2_releases", rel_cnt, 3);
        chk("t2_drops", drop_cnt, 0);

        // Held press saturates the queue and drops the overflow.
        clear_counts();
        for (int i = 0; i < 6; i++) step(1'b1);
        idle(40);
        chk("t3_drops", drop_cnt, 2);
        chk("t3_releases", rel_cnt, 4);

        // Press exactly at GAP end with empty queue restarts without an idle cycle.
        step(1'b1);
        idle(7);
        chk("t4_gap_high", PB_out, 1);
        step(1'b1);
        chk("t4_direct_low", PB_out, 0);
        chk("t4_direct_pend", pending, 0);
        idle(12);

        // Press coinciding with a take from a full queue leaves pending unchanged.
        for (int i = 0; i < 4; i++) step(1'b1);
        chk("t4_full", pending, QD);
        idle(4);
        step(1'b1);
        chk("t4_full_take_pend", pending, QD);
        chk("t4_full_take_drop", dropped, 0);
        idle(40);

        // Asynchronous reset two cycles into a low pulse.
        step(1'b1);
        step(1'b0);
        chk("t5_low_before", PB_out, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_pb", PB_out, 1);
        chk("t5_async_pend", pending, 0);
        chk("t5_async_busy", busy, 0);
        repeat (2) begin
            @(negedge clk);
            chk("t5_no_release", release_sent, 0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            step(i == 0);
            chk("t5_pb", PB_out, pb_exp[i]);
            chk("t5_rs", release_sent, i == 4);
        end

        // Random bursts: every request is either released on the line or dropped.
        clear_counts();
        for (int b = 0; b < 20; b++) begin
            int len, gap;
            len = $urandom_range(1, 8);
            gap = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) begin
                p = ($urandom_range(0, 3) != 0);
                step(p);
            end
            idle(gap);
        end
        idle(60);
        chk("t6_rel_vs_model", rel_cnt, m_takes);
        chk("t6_rel_plus_drop", rel_cnt + drop_cnt, press_cnt);
        chk("t6_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout edge=%0d", t);
        $fatal(1, "timeout");
    end
endmodule
